// File: rtl/z80_bus_cycle_fsm_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : z80_bus_cycle_fsm_if                                          |
// | Purpose  : Bundles the cycle-request handshake and the Z80 bus pins      |
// |            driven or observed by z80_bus_cycle_fsm.                       |
// | Ports    : request side  - start, cyc_type, addr, wdata, ready, done,    |
// |                           rdata, r_wr, r_wdata (refresh register load)   |
// |            bus side      - data_in, data_out, data_oe, addr_out, WAIT_L, |
// |                           M1_L, MREQ_L, IORQ_L, RD_L, WR_L, RFSH_L       |
// |            master: decoder plus external bus; slave: the sequencer.      |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
interface z80_bus_cycle_fsm_if;
  logic        start;
  logic [2:0]  cyc_type;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic        ready;
  logic        done;
  logic [7:0]  rdata;
  logic        r_wr;      // load refresh register R (honoured while idle)
  logic [7:0]  r_wdata;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic        data_oe;
  logic [15:0] addr_out;
  logic        WAIT_L;
  logic        M1_L;
  logic        MREQ_L;
  logic        IORQ_L;
  logic        RD_L;
  logic        WR_L;
  logic        RFSH_L;

  modport master (
    output start, cyc_type, addr, wdata, r_wr, r_wdata, data_in, WAIT_L,
    input  ready, done, rdata, data_out, data_oe, addr_out,
           M1_L, MREQ_L, IORQ_L, RD_L, WR_L, RFSH_L
  );

  modport slave (
    input  start, cyc_type, addr, wdata, r_wr, r_wdata, data_in, WAIT_L,
    output ready, done, rdata, data_out, data_oe, addr_out,
           M1_L, MREQ_L, IORQ_L, RD_L, WR_L, RFSH_L
  );
endinterface
`default_nettype wire

// File: rtl/z80_bus_cycle_fsm.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : z80_bus_cycle_fsm                                             |
// | Purpose  : Z80 machine-cycle sequencer: OCF, MRD, MWR, IORD, IOWR with   |
// |            WAIT_L handling, automatic wait states and DRAM refresh addr. |
// | Ports    : clk   - rising-edge clock                                     |
// |            rst_L - asynchronous active-low reset                         |
// |            bus   - z80_bus_cycle_fsm_if.slave (request + bus pins)       |
// | Params   : MEM_WAIT / IO_WAIT / OCF_WAIT - auto Tw states (0-7)          |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module z80_bus_cycle_fsm #(
  parameter int unsigned MEM_WAIT = 0,
  parameter int unsigned IO_WAIT  = 1,
  parameter int unsigned OCF_WAIT = 0
) (
  input wire                 clk,
  input wire                 rst_L,
  z80_bus_cycle_fsm_if.slave bus
);

  localparam logic [2:0] CYC_OCF  = 3'd0;
  localparam logic [2:0] CYC_MRD  = 3'd1;
  localparam logic [2:0] CYC_MWR  = 3'd2;
  localparam logic [2:0] CYC_IORD = 3'd3;
  localparam logic [2:0] CYC_IOWR = 3'd4;

  localparam logic [2:0] MEM_W = 3'(MEM_WAIT);
  localparam logic [2:0] IO_W  = 3'(IO_WAIT);
  localparam logic [2:0] OCF_W = 3'(OCF_WAIT);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_T1   = 3'd1,
    ST_T2   = 3'd2,
    ST_TW   = 3'd3,
    ST_T3   = 3'd4,
    ST_T4   = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  cyc_q, cyc_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [2:0]  wcnt_q, wcnt_d;
  logic [7:0]  rdata_q, rdata_d;
  logic [7:0]  rfsh_q, rfsh_d;

  logic        final_st;
  logic        accept;
  logic        is_read;
  logic        is_write;
  logic [2:0]  wcnt_dec;

  // The last T-state of a cycle doubles as the accept slot for the next one.
  assign final_st = (state_q == ST_T4) ||
                    ((state_q == ST_T3) && (cyc_q != CYC_OCF));
  assign accept   = bus.start && ((state_q == ST_IDLE) || final_st) &&
                    (bus.cyc_type <= CYC_IOWR);
  assign is_read  = (cyc_q == CYC_OCF) || (cyc_q == CYC_MRD) || (cyc_q == CYC_IORD);
  assign is_write = (cyc_q == CYC_MWR) || (cyc_q == CYC_IOWR);
  assign wcnt_dec = (wcnt_q != 3'd0) ? wcnt_q - 3'd1 : 3'd0;

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state_q <= ST_IDLE;
      cyc_q   <= CYC_OCF;
      addr_q  <= 16'h0000;
      wdata_q <= 8'h00;
      wcnt_q  <= 3'd0;
      rdata_q <= 8'h00;
      rfsh_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wcnt_q  <= wcnt_d;
      rdata_q <= rdata_d;
      rfsh_q  <= rfsh_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wcnt_d  = wcnt_q;
    rdata_d = rdata_q;
    rfsh_d  = rfsh_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.r_wr) rfsh_d = bus.r_wdata;
      end
      ST_T1: begin
        state_d = ST_T2;
        case (cyc_q)
          CYC_OCF:          wcnt_d = OCF_W;
          CYC_MRD, CYC_MWR: wcnt_d = MEM_W;
          default:          wcnt_d = IO_W;
        endcase
      end
      ST_T2: begin
        state_d = ((wcnt_q != 3'd0) || !bus.WAIT_L) ? ST_TW : ST_T3;
      end
      ST_TW: begin
        // Exit is judged on the post-decrement count so N auto waits give N Tw.
        wcnt_d  = wcnt_dec;
        state_d = ((wcnt_dec != 3'd0) || !bus.WAIT_L) ? ST_TW : ST_T3;
      end
      ST_T3: begin
        state_d = (cyc_q == CYC_OCF) ? ST_T4 : ST_IDLE;
      end
      ST_T4: begin
        state_d = ST_IDLE;
        rfsh_d  = {rfsh_q[7], rfsh_q[6:0] + 7'd1};
      end
      default: state_d = ST_IDLE;
    endcase

    if (((state_q == ST_T2) || (state_q == ST_TW)) && (state_d == ST_T3) && is_read)
      rdata_d = bus.data_in;

    if (accept) begin
      state_d = ST_T1;
      cyc_d   = bus.cyc_type;
      addr_d  = bus.addr;
      wdata_d = bus.wdata;
    end
  end

  // Moore output decode from the registered state and latched cycle type.
  always_comb begin
    bus.M1_L     = 1'b1;
    bus.MREQ_L   = 1'b1;
    bus.IORQ_L   = 1'b1;
    bus.RD_L     = 1'b1;
    bus.WR_L     = 1'b1;
    bus.RFSH_L   = 1'b1;
    bus.data_oe  = 1'b0;
    bus.addr_out = (state_q == ST_IDLE) ? 16'h0000 : addr_q;

    if (state_q != ST_IDLE) begin
      case (cyc_q)
        CYC_OCF: begin
          if ((state_q == ST_T1) || (state_q == ST_T2) || (state_q == ST_TW)) begin
            bus.M1_L   = 1'b0;
            bus.MREQ_L = 1'b0;
            bus.RD_L   = 1'b0;
          end else begin
            bus.addr_out = {8'h00, rfsh_q};
            bus.RFSH_L   = 1'b0;
            bus.MREQ_L   = (state_q == ST_T3) ? 1'b0 : 1'b1;
          end
        end
        CYC_MRD: begin
          bus.MREQ_L = 1'b0;
          bus.RD_L   = 1'b0;
        end
        default: begin
          // Remaining types assert their strobes from T2 onwards.
          if (state_q != ST_T1) begin
            bus.MREQ_L = (cyc_q == CYC_MWR) ? 1'b0 : 1'b1;
            bus.IORQ_L = ((cyc_q == CYC_IORD) || (cyc_q == CYC_IOWR)) ? 1'b0 : 1'b1;
            bus.RD_L   = (cyc_q == CYC_IORD) ? 1'b0 : 1'b1;
            bus.WR_L   = is_write ? 1'b0 : 1'b1;
          end
          bus.data_oe = is_write;
        end
      endcase
    end
  end

  assign bus.done     = final_st;
  assign bus.ready    = (state_q == ST_IDLE) || final_st;
  assign bus.rdata    = rdata_q;
  assign bus.data_out = wdata_q;

endmodule
`default_nettype wire
